// File: rtl/tx64_rx64_seq.sv
// Sends a 64-bit word as 8 UART bytes with an inter-byte gap and assembles 8 received bytes into a word.
// The first tx_start follows the trigger by one clock; RX discards a partial word after RX_TIMEOUT idle clocks.
module tx64_rx64_seq #(
    parameter int BYTE_GAP   = 28,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int RX_TIMEOUT = 4340
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        manual_start,
    input  logic [63:0] data_in_64,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        tx_busy,
    output logic        tx_frame_done,
    output logic [63:0] data_out_64,
    output logic        out_valid,
    output logic        rx_err
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_GAP} tx_state_t;

    localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam int TW = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;

    tx_state_t   state_q, state_d;
    logic        start_q;
    logic [63:0] sh_q, sh_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic        busy_q, busy_d;
    logic        fdone_q, fdone_d;

    logic [63:0] asm_q, asm_d;
    logic [63:0] dout_q, dout_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic        ov_q, ov_d;
    logic        err_q, err_d;

    logic trig;
    assign trig = manual_start && !start_q;

    // The shift register always presents the next byte at one end, so tx_byte is just a slice of it.
    assign tx_start      = (state_q == S_SEND);
    assign tx_byte       = MSB_FIRST ? sh_q[63:56] : sh_q[7:0];
    assign tx_busy       = busy_q;
    assign tx_frame_done = fdone_q;
    assign data_out_64   = dout_q;
    assign out_valid     = ov_q;
    assign rx_err        = err_q;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        byte_cnt_d = byte_cnt_q;
        gap_d      = gap_q;
        busy_d     = busy_q;
        fdone_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    sh_d       = data_in_64;
                    byte_cnt_d = 3'd0;
                    busy_d     = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    sh_d       = MSB_FIRST ? {sh_q[55:0], 8'h00} : {8'h00, sh_q[63:8]};
                    gap_d      = '0;
                    if (byte_cnt_q == 3'd7) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        fdone_d = 1'b1;
                    end else if (BYTE_GAP == 0) begin
                        state_d = S_SEND;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(BYTE_GAP - 1)) begin
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A byte arriving on the timeout cycle wins over the discard.
    always_comb begin
        asm_d    = asm_q;
        dout_d   = dout_q;
        rx_cnt_d = rx_cnt_q;
        tmr_d    = tmr_q;
        ov_d     = 1'b0;
        err_d    = 1'b0;
        if (rx_valid) begin
            asm_d    = MSB_FIRST ? {asm_q[55:0], rx_byte} : {rx_byte, asm_q[63:8]};
            rx_cnt_d = rx_cnt_q + 3'd1;
            tmr_d    = '0;
            if (rx_cnt_q == 3'd7) begin
                dout_d = asm_d;
                ov_d   = 1'b1;
            end
        end else if (rx_cnt_q != 3'd0) begin
            if (tmr_q == TW'(RX_TIMEOUT - 1)) begin
                rx_cnt_d = 3'd0;
                asm_d    = '0;
                tmr_d    = '0;
                err_d    = 1'b1;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            sh_q       <= '0;
            byte_cnt_q <= '0;
            gap_q      <= '0;
            busy_q     <= 1'b0;
            fdone_q    <= 1'b0;
            asm_q      <= '0;
            dout_q     <= '0;
            rx_cnt_q   <= '0;
            tmr_q      <= '0;
            ov_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= manual_start;
            sh_q       <= sh_d;
            byte_cnt_q <= byte_cnt_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            fdone_q    <= fdone_d;
            asm_q      <= asm_d;
            dout_q     <= dout_d;
            rx_cnt_q   <= rx_cnt_d;
            tmr_q      <= tmr_d;
            ov_q       <= ov_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_tx64_rx64_seq.sv
// Two instances (MSB-first and LSB-first) driven by directed vectors; monitors pop expected bytes/words from queues.
module tb_tx64_rx64_seq;
    localparam int TXD = 434;
    localparam int GAP = 28;
    localparam int TMO = 4340;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected output %h, want none", name, act);
    endtask

    // ---------------- instance A: MSB first ----------------
    logic        rst_na, ms_a, tx_start_a, tx_done_a, rxv_a, busy_a, fdone_a, ov_a, err_a;
    logic [63:0] din_a, dout_a;
    logic [7:0]  tx_byte_a, rxb_a;

    tx64_rx64_seq #(.BYTE_GAP(GAP), .MSB_FIRST(1'b1), .RX_TIMEOUT(TMO)) dut_a (
        .clk(clk), .rst_n(rst_na), .manual_start(ms_a), .data_in_64(din_a),
        .tx_start(tx_start_a), .tx_byte(tx_byte_a), .tx_done(tx_done_a),
        .rx_valid(rxv_a), .rx_byte(rxb_a), .tx_busy(busy_a), .tx_frame_done(fdone_a),
        .data_out_64(dout_a), .out_valid(ov_a), .rx_err(err_a));

    // ---------------- instance B: LSB first ----------------
    logic        rst_nb, ms_b, tx_start_b, tx_done_b, rxv_b, busy_b, fdone_b, ov_b, err_b;
    logic [63:0] din_b, dout_b;
    logic [7:0]  tx_byte_b, rxb_b;

    tx64_rx64_seq #(.BYTE_GAP(GAP), .MSB_FIRST(1'b0), .RX_TIMEOUT(TMO)) dut_b (
        .clk(clk), .rst_n(rst_nb), .manual_start(ms_b), .data_in_64(din_b),
        .tx_start(tx_start_b), .tx_byte(tx_byte_b), .tx_done(tx_done_b),
        .rx_valid(rxv_b), .rx_byte(rxb_b), .tx_busy(busy_b), .tx_frame_done(fdone_b),
        .data_out_64(dout_b), .out_valid(ov_b), .rx_err(err_b));

    // UART TX models: tx_done comes TXD clocks after each tx_start
    initial begin
        tx_done_a = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_a === 1'b1) begin
                repeat (TXD) @(posedge clk);
                #1 tx_done_a = 1'b1;
                @(posedge clk);
                #1 tx_done_a = 1'b0;
            end
        end
    end

    initial begin
        tx_done_b = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_b === 1'b1) begin
                repeat (TXD) @(posedge clk);
                #1 tx_done_b = 1'b1;
                @(posedge clk);
                #1 tx_done_b = 1'b0;
            end
        end
    end

    // ---------------- scoreboards / monitors ----------------
    logic [7:0]  qa[$], qb[$];
    logic [63:0] rqa[$], rqb[$];
    int frames_a = 0, frames_b = 0, rxerr_a = 0, rxerr_b = 0;
    int last_done_a = -1, last_done_b = -1;

    always @(negedge clk) begin
        if (!rst_na) last_done_a = -1;
        if (tx_start_a) begin
            if (qa.size() == 0) unexpected("tx_byte_a", 64'(tx_byte_a));
            else check("tx_byte_a", 64'(tx_byte_a), 64'(qa.pop_front()));
            if (last_done_a >= 0) check("gap_a", 64'(cyc - last_done_a), 64'(GAP + 1));
            last_done_a = -1;
        end
        if (tx_done_a && busy_a) last_done_a = cyc;
        if (fdone_a) begin
            frames_a++;
            check("busy_at_frame_done_a", 64'(busy_a), 64'd0);
            last_done_a = -1;
        end
        if (ov_a) begin
            if (rqa.size() == 0) unexpected("data_out_a", dout_a);
            else check("data_out_a", dout_a, rqa.pop_front());
        end
        if (err_a) rxerr_a++;
    end

    always @(negedge clk) begin
        if (!rst_nb) last_done_b = -1;
        if (tx_start_b) begin
            if (qb.size() == 0) unexpected("tx_byte_b", 64'(tx_byte_b));
            else check("tx_byte_b", 64'(tx_byte_b), 64'(qb.pop_front()));
            if (last_done_b >= 0) check("gap_b", 64'(cyc - last_done_b), 64'(GAP + 1));
            last_done_b = -1;
        end
        if (tx_done_b && busy_b) last_done_b = cyc;
        if (fdone_b) begin
            frames_b++;
            last_done_b = -1;
        end
        if (ov_b) begin
            if (rqb.size() == 0) unexpected("data_out_b", dout_b);
            else check("data_out_b", dout_b, rqb.pop_front());
        end
        if (err_b) rxerr_b++;
    end

    // ---------------- helpers ----------------
    task automatic push_msb(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) qa.push_back(w[63-8*i -: 8]);
    endtask

    task automatic push_lsb(input logic [63:0] w, input int n);
        for (int i = 0; i < n; i++) qb.push_back(w[8*i +: 8]);
    endtask

    task automatic rx_a(input logic [7:0] b);
        @(posedge clk);
        #1 rxb_a = b; rxv_a = 1'b1;
        @(posedge clk);
        #1 rxv_a = 1'b0;
    endtask

    task automatic rx_b(input logic [7:0] b);
        @(posedge clk);
        #1 rxb_b = b; rxv_b = 1'b1;
        @(posedge clk);
        #1 rxv_b = 1'b0;
    endtask

    task automatic rx_word_a(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            rx_a(w[63-8*i -: 8]);
            repeat (6) @(posedge clk);
        end
    endtask

    task automatic wait_frames_a(input int n);
        for (int k = 0; k < 20000 && frames_a < n; k++) @(posedge clk);
        #1 check("frames_a", 64'(frames_a), 64'(n));
    endtask

    task automatic retrigger_a();
        @(posedge clk);
        #1 ms_a = 1'b0;
        @(posedge clk);
        #1 ms_a = 1'b1;
    endtask

    // ---------------- stimulus A ----------------
    task automatic run_a();
        rst_na = 1'b0; ms_a = 1'b1; din_a = 64'hA1A34D6FF6B2C581; rxv_a = 1'b0; rxb_a = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start_a", 64'(tx_start_a), 64'd0);
        check("rst_tx_byte_a", 64'(tx_byte_a), 64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_dout_a", dout_a, 64'd0);
        check("rst_pulses_a", {61'd0, fdone_a, ov_a, err_a}, 64'd0);

        // frame 1: manual_start high at reset release triggers once
        push_msb(64'hA1A34D6FF6B2C581, 8);
        rst_na = 1'b1;
        @(posedge clk);
        #1 check("busy_after_trigger_a", 64'(busy_a), 64'd1);
        wait_frames_a(1);

        // held-high start with new data must not send a second frame
        din_a = 64'h44233E79479427F7;
        repeat (300) @(posedge clk);
        #1 check("no_second_frame_busy_a", 64'(busy_a), 64'd0);
        check("frame1_drained_a", 64'(qa.size()), 64'd0);

        // frame 2, with an ignored trigger edge during byte 3
        push_msb(64'h44233E79479427F7, 8);
        retrigger_a();
        for (int k = 0; k < 5000 && qa.size() > 5; k++) @(posedge clk);
        repeat (100) @(posedge clk);
        #1 ms_a = 1'b0; din_a = 64'hDEADBEEFCAFEF00D;
        retrigger_a();
        wait_frames_a(2);
        repeat (50) @(posedge clk);
        #1 check("frame2_single_a", 64'(frames_a), 64'd2);

        // RX: full word, then timeout discard, then boundary timeout
        rqa.push_back(64'h44233E79479427F7);
        rx_word_a(64'h44233E79479427F7);
        #1 check("rx_word1_a", dout_a, 64'h44233E79479427F7);

        rx_a(8'h5A); rx_a(8'h6B); rx_a(8'h7C);
        repeat (4339) @(posedge clk);
        @(negedge clk) check("rx_err_not_early_a", 64'(err_a), 64'd0);
        @(negedge clk) check("rx_err_on_time_a", 64'(err_a), 64'd1);
        repeat (5) @(posedge clk);
        #1 check("rx_err_count_a", 64'(rxerr_a), 64'd1);
        check("dout_kept_a", dout_a, 64'h44233E79479427F7);

        rqa.push_back(64'h0102030405060708);
        rx_word_a(64'h0102030405060708);

        rqa.push_back(64'h1122334455667788);
        rx_a(8'h11); rx_a(8'h22); rx_a(8'h33);
        repeat (TMO - 2) @(posedge clk);
        rx_a(8'h44);
        rx_a(8'h55); rx_a(8'h66); rx_a(8'h77); rx_a(8'h88);
        repeat (10) @(posedge clk);
        #1 check("rx_boundary_no_err_a", 64'(rxerr_a), 64'd1);
        check("rx_queue_drained_a", 64'(rqa.size()), 64'd0);

        // frame 3 aborted by reset during byte 5, RX partial word aborted too
        din_a = 64'h0123456789ABCDEF;
        push_msb(64'h0123456789ABCDEF, 5);
        retrigger_a();
        for (int k = 0; k < 5000 && qa.size() > 0; k++) @(posedge clk);
        rx_a(8'h99); rx_a(8'h98);
        repeat (50) @(posedge clk);
        #1 rst_na = 1'b0; ms_a = 1'b0;
        #1;
        check("abort_busy_a", 64'(busy_a), 64'd0);
        check("abort_tx_byte_a", 64'(tx_byte_a), 64'd0);
        check("abort_tx_start_a", 64'(tx_start_a), 64'd0);
        check("abort_dout_a", dout_a, 64'd0);
        repeat (5) @(posedge clk);
        #1 rst_na = 1'b1;
        repeat (TMO + 200) @(posedge clk);
        #1;
        check("abort_frames_a", 64'(frames_a), 64'd2);
        check("abort_rx_err_a", 64'(rxerr_a), 64'd1);
        check("abort_tx_drained_a", 64'(qa.size()), 64'd0);
        check("abort_idle_busy_a", 64'(busy_a), 64'd0);
    endtask

    // ---------------- stimulus B ----------------
    task automatic run_b();
        logic [63:0] w;
        w = 64'hA1A34D6FF6B2C581;
        rst_nb = 1'b0; ms_b = 1'b1; din_b = w; rxv_b = 1'b0; rxb_b = 8'h00;
        repeat (3) @(posedge clk);
        #1 check("rst_busy_b", 64'(busy_b), 64'd0);
        push_lsb(w, 8);
        rst_nb = 1'b1;
        rqb.push_back(w);
        for (int i = 0; i < 8; i++) begin
            rx_b(w[8*i +: 8]);
            repeat (3) @(posedge clk);
        end
        for (int k = 0; k < 20000 && frames_b < 1; k++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        check("frames_b", 64'(frames_b), 64'd1);
        check("tx_drained_b", 64'(qb.size()), 64'd0);
        check("rx_drained_b", 64'(rqb.size()), 64'd0);
        check("rx_err_b", 64'(rxerr_b), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time %0t, want completion earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
